seq_prog: RTL and testbench
===========================

# seq_prog

Programmable, parametrised successor to the fixed-pattern symbol sequence detector. It detects a runtime-loadable pattern of up to MAX_LEN symbols, each DATA_WIDTH bits wide, in a qualified symbol stream. It supports overlapping and non-overlapping detection and an optional saturating match counter. It sits directly on the symbol stream in place of the fixed detector, with configuration driven from a control block.

## Interface
- DATA_WIDTH, 4, symbol width in bits
- MAX_LEN, 8, maximum pattern length in symbols (2..16)
- CNT_WIDTH, 8, match counter width (only used with SEQ_PROG_COUNT_EN)
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  detector enable; configuration is accepted only while low
- cfg_we  input  1  pattern symbol write strobe
- cfg_idx  input  $clog2(MAX_LEN)  pattern slot written (0 = first symbol of the sequence)
- cfg_sym  input  DATA_WIDTH  symbol value written
- cfg_len_we  input  1  length/mode write strobe
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- in_valid  input  1  in_symbol qualifier
- in_symbol  input  DATA_WIDTH  stream symbol
- match  output  1  registered one-cycle pulse per detected occurrence
- match_count  output  CNT_WIDTH  saturating count of matches (only with SEQ_PROG_COUNT_EN)

## Operation
- Reset values:
  - pattern slots 0..4 = 1,2,1,3,1; remaining slots = 0
  - len = 5, overlap = 1
  - history empty (fill = 0), match = 0, match_count = 0
- Configuration:
  - cfg_we and cfg_len_we take effect only when en = 0; they are ignored while en = 1.
  - cfg_idx ≥ MAX_LEN is ignored.
  - cfg_len is clamped to MAX_LEN. Length 0 means the detector never matches.
- States:
  - DISABLED (en = 0): history is cleared every cycle (fill = 0) and match = 0.
  - RUN (en = 1): history is active. Transition DISABLED → RUN on the cycle en is sampled high. The first symbol accepted is the symbol with in_valid high in that same cycle.
- History:
  - A shift buffer holds the last MAX_LEN−1 accepted symbols.
  - fill counts valid entries and saturates at MAX_LEN−1.
  - Only cycles with in_valid = 1 and en = 1 shift the buffer or change fill.
- Hit condition, on an accepted symbol:
  - len ≥ 1 and fill ≥ len−1, and
  - in_symbol == pattern[len−1], and
  - the history entries at ages 1..len−1 equal pattern[len−2..0].
  - For len = 1, only the in_symbol compare applies.
- On a hit:
  - Overlap = 1: history updates normally.
  - Overlap = 0: fill is set to 0 after the shift, so the next match needs len fresh symbols.
- Full pattern compare replaces suffix-fallback states. Overlaps (for example a trailing 1 restarting 1,2,1,3,1) are therefore found automatically.

## Timing
- match is asserted in the cycle after the final symbol of the pattern is accepted. It lasts exactly one cycle per hit and can be high in consecutive cycles when hits are consecutive.
- A cycle with in_valid = 0 never produces a hit and leaves the history untouched. Gaps are transparent.
- reset asserted mid-sequence: on the next edge, match = 0, fill = 0, counter = 0 and configuration returns to its defaults. A hit pending in that cycle is discarded.
- en falling in the cycle after a hit: the registered match pulse is still delivered. From the following cycle match stays 0.
- Configuration written on edge N is used by a detector enabled at edge N+1 or later.

## Configuration
- SEQ_PROG_COUNT_EN defined:
  - The match_count port and register exist.
  - The counter increments on every cycle match = 1 and saturates at 2^CNT_WIDTH−1.
  - The counter is cleared by reset only. en does not clear it.
- SEQ_PROG_COUNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package seq_pkg holds:
  - the state enum (DISABLED, RUN)
  - the default pattern constants (1,2,1,3,1) and the default length 5
  - a width helper for the cfg_idx and cfg_len widths
- One sub-module, seq_hist: the parametrised shift buffer with its fill counter. It exposes the flattened history and fill, and has inputs shift, clear and din.
- The compare and match logic stay in seq_prog.

## Test plan
- Defaults after reset, en = 1, symbols 1,2,1,3,1 on consecutive cycles → match high exactly one cycle after the fifth symbol; match_count = 1.
- Overlap: 1,2,1,3,1,2,1,3,1 → two match pulses with overlap = 1, spaced 4 cycles apart. With overlap = 0, only one pulse.
- Reprogram with en = 0: len = 3, pattern 7,7,7. Input 7 × 5 → matches after the 3rd, 4th and 5th symbols (overlap = 1); after the 3rd only (overlap = 0).
- Gaps and writes: 1,2,1,3,1 with in_valid low for 2 cycles between each symbol → a single match after the final 1. A cfg_we attempted while en = 1 → the pattern is unchanged.
- Boundaries:
  - reset asserted after 1,2,1,3 then 1 → no match.
  - cfg_len = 0 → no match on any stream.
  - cfg_len = 15 with MAX_LEN = 8 → effective length 8.
- With SEQ_PROG_COUNT_EN and CNT_WIDTH = 2: six matches → match_count sticks at 3.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the programmable sequence detector.
// Holds the detector state enum, the power-on pattern (1,2,1,3,1) with its
// length, and a width helper used to size the configuration ports.
package seq_pkg;

    typedef enum logic {
        DISABLED = 1'b0,
        RUN      = 1'b1
    } seq_state_e;

    localparam int DEF_LEN = 5;

    // Power-on pattern symbol for a slot; slots past the default pattern are 0.
    function automatic int def_sym(input int slot);
        case (slot)
            0:       return 1;
            1:       return 2;
            2:       return 1;
            3:       return 3;
            4:       return 1;
            default: return 0;
        endcase
    endfunction

    // Bits needed to encode n distinct values (at least one bit).
    function automatic int w_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_hist.sv
// seq_hist: history shift buffer of the last DEPTH accepted symbols plus a
// saturating fill counter. Entry 0 is the most recent symbol (age 1).
// clear zeroes fill only; stale data behind fill is never compared.
module seq_hist #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 7,
    parameter int FILL_W     = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shift,
    input  logic                        clear,
    input  logic [DATA_WIDTH-1:0]       din,
    output logic [DEPTH*DATA_WIDTH-1:0] hist,
    output logic [FILL_W-1:0]           fill
);

    logic [DATA_WIDTH-1:0] sym_q [DEPTH];
    logic [DATA_WIDTH-1:0] sym_d [DEPTH];
    logic [FILL_W-1:0]     fill_q;
    logic [FILL_W-1:0]     fill_d;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_head
                assign sym_d[gi] = shift ? din : sym_q[gi];
            end else begin : g_tail
                assign sym_d[gi] = shift ? sym_q[gi-1] : sym_q[gi];
            end
            assign hist[gi*DATA_WIDTH +: DATA_WIDTH] = sym_q[gi];
        end
    endgenerate

    // Fill grows with each shift up to DEPTH; clear wins over the increment.
    always_comb begin
        fill_d = fill_q;
        if (shift && (fill_q != FILL_W'(DEPTH))) begin
            fill_d = fill_q + FILL_W'(1);
        end
        if (clear) begin
            fill_d = '0;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sym_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                sym_q[i] <= sym_d[i];
            end
            fill_q <= fill_d;
        end
    end

    assign fill = fill_q;

endmodule

// File: rtl/seq_prog.sv
// seq_prog: runtime-programmable symbol sequence detector.
// The pattern, length and overlap mode are loadable while en is low. A hit
// compares the incoming symbol and the history window against the whole
// pattern at once, so overlapping occurrences need no fallback states.
// Optional feature macro: SEQ_PROG_COUNT_EN adds the saturating match_count.
module seq_prog
    import seq_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int MAX_LEN    = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        cfg_we,
    input  logic [w_of(MAX_LEN)-1:0]    cfg_idx,
    input  logic [DATA_WIDTH-1:0]       cfg_sym,
    input  logic                        cfg_len_we,
    input  logic [w_of(MAX_LEN+1)-1:0]  cfg_len,
    input  logic                        cfg_overlap,
    input  logic                        in_valid,
    input  logic [DATA_WIDTH-1:0]       in_symbol,
`ifdef SEQ_PROG_COUNT_EN
    output logic                        match,
    output logic [CNT_WIDTH-1:0]        match_count
`else
    output logic                        match
`endif
);

    localparam int LW      = w_of(MAX_LEN + 1);
    localparam int FW      = w_of(MAX_LEN);
    localparam int DEPTH   = MAX_LEN - 1;
    localparam int RST_LEN = (DEF_LEN > MAX_LEN) ? MAX_LEN : DEF_LEN;

    seq_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] pat_q [MAX_LEN];
    logic [DATA_WIDTH-1:0] pat_d [MAX_LEN];
    logic [LW-1:0]         len_q, len_d;
    logic                  overlap_q, overlap_d;
    logic                  match_q, match_d;

    logic                  cfg_ok;
    logic                  accept;
    logic                  leave_run;
    logic                  hit;
    logic                  hist_clear;
    logic [DEPTH*DATA_WIDTH-1:0] hist_flat;
    logic [FW-1:0]         fill;
    logic [DATA_WIDTH-1:0] win [MAX_LEN];

    seq_hist #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .FILL_W     (FW)
    ) u_hist (
        .clk   (clk),
        .reset (reset),
        .shift (accept),
        .clear (hist_clear),
        .din   (in_symbol),
        .hist  (hist_flat),
        .fill  (fill)
    );

    // Window by age: age 0 is the live symbol, ages 1.. come from history.
    generate
        assign win[0] = in_symbol;
        for (genvar gi = 1; gi < MAX_LEN; gi++) begin : g_win
            assign win[gi] = hist_flat[(gi-1)*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Next state follows en directly so the rising cycle already accepts.
    always_comb begin
        state_d = en ? RUN : DISABLED;
    end

    // State decode: configuration gate, symbol acceptance, history flush on exit.
    always_comb begin
        cfg_ok    = (state_d == DISABLED);
        accept    = (state_d == RUN) && in_valid;
        leave_run = (state_q == RUN) && (state_d == DISABLED);
    end

    // Configuration writes, ignored while running; length clamps to MAX_LEN.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        if (cfg_ok) begin
            if (cfg_we) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (32'(cfg_idx) == i) begin
                        pat_d[i] = cfg_sym;
                    end
                end
            end
            if (cfg_len_we) begin
                len_d     = (32'(cfg_len) > MAX_LEN) ? LW'(MAX_LEN) : cfg_len;
                overlap_d = cfg_overlap;
            end
        end
    end

    // Whole-pattern compare: pattern slot j must sit at age len-1-j.
    always_comb begin
        hit = 1'b0;
        if (accept && (len_q != '0) && ((32'(fill) + 32'd1) >= 32'(len_q))) begin
            hit = 1'b1;
            for (int j = 0; j < MAX_LEN; j++) begin
                for (int a = 0; a < MAX_LEN; a++) begin
                    if (((j + a + 1) == int'(len_q)) && (win[a] != pat_q[j])) begin
                        hit = 1'b0;
                    end
                end
            end
        end
    end

    assign hist_clear = leave_run || (hit && !overlap_q);
    assign match_d    = hit;

    // State, configuration and match registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DISABLED;
            for (int i = 0; i < MAX_LEN; i++) begin
                pat_q[i] <= DATA_WIDTH'(def_sym(i));
            end
            len_q     <= LW'(RST_LEN);
            overlap_q <= 1'b1;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            match_q   <= match_d;
        end
    end

    assign match = match_q;

`ifdef SEQ_PROG_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Count every delivered pulse, holding at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (match_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register, cleared by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_count = cnt_q;
`endif

endmodule

// File: tb/tb_seq_prog.sv
// tb_seq_prog: directed bench for seq_prog (DATA_WIDTH 4, MAX_LEN 8, CNT_WIDTH 2).
// A queue-based model of the accepted stream predicts match every cycle;
// directed tests also pin pulse counts and timing with literal values.
module tb_seq_prog;

    logic       clk;
    logic       reset;
    logic       en;
    logic       cfg_we;
    logic [2:0] cfg_idx;
    logic [3:0] cfg_sym;
    logic       cfg_len_we;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       in_valid;
    logic [3:0] in_symbol;
    logic       match;
`ifdef SEQ_PROG_COUNT_EN
    logic [1:0] match_count;
`endif

    seq_prog #(
        .DATA_WIDTH (4),
        .MAX_LEN    (8),
        .CNT_WIDTH  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_sym     (cfg_sym),
        .cfg_len_we  (cfg_len_we),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_symbol   (in_symbol),
`ifdef SEQ_PROG_COUNT_EN
        .match_count (match_count),
`endif
        .match       (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int pulses  = 0;
    int cyc     = 0;
    int pulse_cyc [$];

    // Model: accepted symbols since the last enable / non-overlap hit.
    int  m_pat [8];
    int  m_len;
    bit  m_ovl;
    int  m_q [$];
    bit  exp_match = 1'b0;
    int  exp_cnt   = 0;

    always @(posedge clk) begin
        bit h;
        h = 1'b0;
        cyc++;
        if (reset) begin
            m_pat = '{1, 2, 1, 3, 1, 0, 0, 0};
            m_len = 5;
            m_ovl = 1'b1;
            m_q.delete();
            exp_cnt = 0;
        end else begin
            if (exp_match && exp_cnt < 3) exp_cnt++;
            if (!en) begin
                m_q.delete();
                if (cfg_we) m_pat[cfg_idx] = int'(cfg_sym);
                if (cfg_len_we) begin
                    m_len = (cfg_len > 4'd8) ? 8 : int'(cfg_len);
                    m_ovl = cfg_overlap;
                end
            end else if (in_valid) begin
                m_q.push_back(int'(in_symbol));
                if (m_q.size() > 16) void'(m_q.pop_front());
                if (m_len > 0 && m_q.size() >= m_len) begin
                    h = 1'b1;
                    for (int j = 0; j < m_len; j++)
                        if (m_q[m_q.size() - m_len + j] != m_pat[j]) h = 1'b0;
                end
                if (h && !m_ovl) m_q.delete();
            end
        end
        exp_match = h;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        vectors++;
        if (match !== exp_match) begin
            fails++;
            $display("FAIL match_model cyc=%0d got=%b exp=%b", cyc, match, exp_match);
        end
        if (match === 1'b1) begin
            pulses++;
            pulse_cyc.push_back(cyc);
        end
`ifdef SEQ_PROG_COUNT_EN
        vectors++;
        if (match_count !== 2'(exp_cnt)) begin
            fails++;
            $display("FAIL count_model cyc=%0d got=%0d exp=%0d", cyc, match_count, exp_cnt);
        end
`endif
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input bit v, input int s);
        in_valid  = v;
        in_symbol = s[3:0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0);
    endtask

    // Feed n symbols packed as hex digits, first symbol most significant.
    task automatic feed(input logic [63:0] s, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, int'(s[4*(n-1-i) +: 4]));
            if (i != n - 1) idle(gap);
        end
    endtask

    task automatic wr_sym(input int idx, input int sym);
        cfg_we  = 1'b1;
        cfg_idx = idx[2:0];
        cfg_sym = sym[3:0];
        idle(1);
        cfg_we  = 1'b0;
    endtask

    task automatic wr_len(input int len, input bit ovl);
        cfg_len_we  = 1'b1;
        cfg_len     = len[3:0];
        cfg_overlap = ovl;
        idle(1);
        cfg_len_we  = 1'b0;
    endtask

    task automatic restart();
        pulses = 0;
        pulse_cyc.delete();
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sym = '0;
        cfg_len_we = 1'b0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; in_symbol = '0;
        @(negedge clk);
        idle(1);
        check("reset_match", int'(match), 0);
`ifdef SEQ_PROG_COUNT_EN
        check("reset_count", int'(match_count), 0);
`endif
        reset = 1'b0;

        // Default pattern, consecutive symbols.
        en = 1'b1;
        restart();
        feed(64'h1213, 4, 0);
        check("pre_match", int'(match), 0);
        step(1'b1, 1);
        check("match_after_5th", int'(match), 1);
        idle(1);
        check("match_one_cycle", int'(match), 0);
        $display("test defaults: pulses=%0d", pulses);
        check("defaults_pulses", pulses, 1);
`ifdef SEQ_PROG_COUNT_EN
        check("count_one", int'(match_count), 1);
`endif

        // Overlapping occurrences, then non-overlapping mode.
        en = 1'b0; idle(1); en = 1'b1;
        restart();
        feed(64'h121312131, 9, 0);
        idle(1);
        $display("test overlap1: pulses=%0d", pulses);
        check("overlap1_pulses", pulses, 2);
        check("overlap1_spacing", (pulse_cyc.size() == 2) ? pulse_cyc[1] - pulse_cyc[0] : -1, 4);
        en = 1'b0; wr_len(5, 1'b0); en = 1'b1;
        restart();
        feed(64'h121312131, 9, 0);
        idle(1);
        $display("test overlap0: pulses=%0d", pulses);
        check("overlap0_pulses", pulses, 1);

        // Reprogrammed 7,7,7.
        en = 1'b0;
        wr_sym(0, 7); wr_sym(1, 7); wr_sym(2, 7);
        wr_len(3, 1'b1);
        en = 1'b1;
        restart();
        feed(64'h77777, 5, 0);
        idle(1);
        $display("test sevens_ovl1: pulses=%0d", pulses);
        check("sevens_ovl1_pulses", pulses, 3);
        check("sevens_consecutive", (pulse_cyc.size() == 3) ? pulse_cyc[2] - pulse_cyc[0] : -1, 2);
        en = 1'b0; wr_len(3, 1'b0); en = 1'b1;
        restart();
        feed(64'h77777, 5, 0);
        idle(1);
        $display("test sevens_ovl0: pulses=%0d", pulses);
        check("sevens_ovl0_pulses", pulses, 1);
`ifdef SEQ_PROG_COUNT_EN
        check("count_saturated", int'(match_count), 3);
`endif

        // Defaults again; write attempt while running; gapped stream.
        reset = 1'b1; idle(1); reset = 1'b0;
        en = 1'b1;
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_sym = 4'd9;
        idle(1);
        cfg_we = 1'b0;
        restart();
        feed(64'h12131, 5, 2);
        idle(1);
        $display("test gaps: pulses=%0d", pulses);
        check("gaps_pulses", pulses, 1);

        // Reset in the cycle of the final symbol, then the final symbol again.
        restart();
        feed(64'h1213, 4, 0);
        reset = 1'b1;
        step(1'b1, 1);
        reset = 1'b0;
        check("reset_discard", int'(match), 0);
        step(1'b1, 1);
        idle(1);
        $display("test reset_mid: pulses=%0d", pulses);
        check("reset_mid_pulses", pulses, 0);
`ifdef SEQ_PROG_COUNT_EN
        check("count_after_reset", int'(match_count), 0);
`endif

        // Length 0 never matches.
        en = 1'b0; wr_len(0, 1'b1); en = 1'b1;
        restart();
        feed(64'h12131, 5, 0);
        feed(64'h0000, 4, 0);
        idle(1);
        $display("test len0: pulses=%0d", pulses);
        check("len0_pulses", pulses, 0);

        // Length 15 clamps to 8 with pattern 1..8; en drops right after the hit.
        en = 1'b0;
        for (int i = 0; i < 8; i++) wr_sym(i, i + 1);
        wr_len(15, 1'b1);
        en = 1'b1;
        restart();
        feed(64'h2345678, 7, 0);
        idle(1);
        check("len8_partial", pulses, 0);
        feed(64'h12345678, 8, 0);
        check("len8_match", int'(match), 1);
        en = 1'b0;
        step(1'b1, 8);
        check("en_low_after_hit", int'(match), 0);
        idle(1);
        $display("test len_clamp: pulses=%0d", pulses);
        check("len8_pulses", pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
